boot_rom_if: RTL and testbench
==============================

Name: boot_rom_if

Overview:
- Bus slave that sits directly upstream of the boot ROM macro and connects the core's instruction/data request port (req/gnt/rvalid protocol) to it.
- Decodes the ROM address window and converts byte addresses to ROM word indices.
- Drives the ROM's active-low chip enable and word address, and returns the ROM's 1-cycle-latency read data as a bus response.
- Rejects writes and out-of-window accesses with an error response and never touches the ROM for them.

Parameters:
- ROM_ADDR_WIDTH, 8: ROM word-index width; ROM holds 2**ROM_ADDR_WIDTH 32-bit words.
- BASE_ADDR, 32'h1A000000: byte base address of the ROM window; must be aligned to 4*2**ROM_ADDR_WIDTH.
- INIT_CYCLES, 2: cycles after reset release before the first grant (1..15).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_req_i  in  1  request valid
- data_gnt_o  out  1  request accepted this cycle
- data_addr_i  in  32  byte address
- data_we_i  in  1  1 = write
- data_be_i  in  4  byte enables (ignored for reads)
- data_wdata_i  in  32  write data (ignored)
- data_rvalid_o  out  1  response valid
- data_rdata_o  out  32  response data
- data_err_o  out  1  response is an error (valid only with rvalid)
- rom_cen_o  out  1  ROM chip enable, active low
- rom_addr_o  out  ROM_ADDR_WIDTH  ROM word index
- rom_q_i  in  32  ROM read data; valid the cycle after rom_cen_o low
- err_count_o  out  8  saturating count of error responses

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0, data_err_o=0, rom_cen_o=1, rom_addr_o=0, err_count_o=0, FSM=INIT, init counter=0.
- FSM INIT:
  - Counts cycles after reset release; no grants are given.
  - Moves to READY when the counter reaches INIT_CYCLES-1.
- FSM READY: data_gnt_o = data_req_i, combinationally. Stays in READY until reset.
- Reset asserted mid-operation: immediately returns every output and the FSM to reset values; an in-flight response is discarded.
- Window hit: data_addr_i[31:ROM_ADDR_WIDTH+2] == BASE_ADDR[31:ROM_ADDR_WIDTH+2]. Address bits [1:0] are ignored; every access is a full-word access.
- Granted read that hits:
  - Same cycle: rom_cen_o=0 and rom_addr_o=data_addr_i[ROM_ADDR_WIDTH+1:2], both combinational.
  - Next cycle: data_rvalid_o=1, data_err_o=0, data_rdata_o=rom_q_i.
- All other cycles: rom_cen_o=1. rom_addr_o holds data_addr_i[ROM_ADDR_WIDTH+1:2] combinationally, so the ROM is unaffected.
- Granted write, or granted read that misses:
  - The ROM is not enabled.
  - Next cycle: data_rvalid_o=1, data_err_o=1, data_rdata_o=0.
  - err_count_o increments in that same response cycle and saturates at 8'hFF.
- Response pipeline: a single registered stage holding {valid, is_err}.
  - data_rdata_o muxes rom_q_i when valid and not is_err, else 0.
  - data_rdata_o = 0 whenever data_rvalid_o=0.
- Latency: exactly 1 cycle from grant to rvalid.
- Throughput: back-to-back grants every cycle; hits, misses and writes may be interleaved freely.
- No backpressure on responses: the master must accept rvalid in the cycle it is asserted.
- Only one transaction per cycle, so request and response never conflict.
- data_req_i may drop without a grant (INIT state); nothing is recorded in that case.

Test Plan:
- Reset, then req held high from the first cycle -> gnt stays 0 for 2 cycles after rst_n rises; first gnt in cycle 3; rom_cen_o stays 1 until that grant.
- ROM preloaded with words 32..34 = 1C008537, 08050513, 00050067; reads at 0x1A000080, 0x1A000084, 0x1A000088 on consecutive cycles -> rom_addr_o = 32, 33, 34 with cen low; rvalid on the 3 following cycles with those values and err=0.
- Write to 0x1A000080 (we=1, be=4'hF, wdata=0x12345678) -> gnt=1, rom_cen_o=1; next cycle rvalid=1, err=1, rdata=0; err_count_o=1; a subsequent read still returns 1C008537.
- Read at 0x1A000400 (first address outside the 1 KiB window) and at 0x00000000 -> error responses, rdata=0, ROM never enabled, err_count_o +2.
- 300 back-to-back write errors -> err_count_o saturates at 8'hFF and holds.
- Read granted, then rst_n pulled low before the response cycle -> rvalid stays 0, err_count_o=0, FSM re-enters INIT and re-counts INIT_CYCLES.

Source files
------------

// File: rtl/boot_rom_if.sv
`timescale 1ns/1ps
// boot_rom_if: req/gnt/rvalid bus slave in front of the boot ROM macro.
// Decodes the ROM window, drives the ROM port and returns 1-cycle read or error responses.
module boot_rom_if #(
  parameter int unsigned ROM_ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR      = 32'h1A000000,
  parameter int unsigned INIT_CYCLES    = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic [31:0]               data_addr_i,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [31:0]               data_rdata_o,
  output logic                      data_err_o,
  output logic                      rom_cen_o,
  output logic [ROM_ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [31:0]               rom_q_i,
  output logic [7:0]                err_count_o
);

  localparam int unsigned TAG_LSB   = ROM_ADDR_WIDTH + 2;
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_e;

  state_e     r_state;
  state_e     w_state_nxt;
  logic [3:0] r_init_cnt;
  logic [3:0] w_init_cnt_nxt;
  logic       r_rsp_valid;
  logic       r_rsp_err;
  logic [7:0] r_err_cnt;
  logic       w_hit;
  logic       w_gnt;
  logic       w_rom_rd;
  logic       w_err_rsp;
  logic       w_unused;

  assign w_hit     = (data_addr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
  assign w_gnt     = (r_state == ST_READY) & data_req_i;
  assign w_rom_rd  = w_gnt & ~data_we_i & w_hit;
  assign w_err_rsp = w_gnt & (data_we_i | ~w_hit);

  // Byte enables, write data and the byte offset never influence a full-word ROM read.
  assign w_unused  = ^{data_be_i, data_wdata_i, data_addr_i[1:0]};

  assign data_gnt_o    = w_gnt;
  assign rom_cen_o     = ~w_rom_rd;
  assign rom_addr_o    = rst_n ? data_addr_i[TAG_LSB-1:2] : {ROM_ADDR_WIDTH{1'b0}};
  assign data_rvalid_o = r_rsp_valid;
  assign data_err_o    = r_rsp_valid & r_rsp_err;
  assign data_rdata_o  = (r_rsp_valid & ~r_rsp_err) ? rom_q_i : 32'h0000_0000;
  assign err_count_o   = r_err_cnt;

  // Next-state logic: count out the post-reset settle time, then serve requests forever.
  always_comb begin
    w_state_nxt    = r_state;
    w_init_cnt_nxt = r_init_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_init_cnt == INIT_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_init_cnt_nxt = r_init_cnt + 4'd1;
        end
      end
      ST_READY: begin
        w_state_nxt = ST_READY;
      end
      default: begin
        w_state_nxt    = ST_INIT;
        w_init_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State and init counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_init_cnt <= w_init_cnt_nxt;
    end
  end

  // Single response stage; the ROM data itself arrives on rom_q_i in the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_gnt;
      r_rsp_err   <= w_err_rsp;
    end
  end

  // Saturating error counter, updated so the new value is visible with the error response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= 8'h00;
    end else if (w_err_rsp && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end else begin
      r_err_cnt <= r_err_cnt;
    end
  end

endmodule

// File: tb/tb_boot_rom_if.sv
`timescale 1ns/1ps
// tb_boot_rom_if: directed stimulus with a behavioural model checked every falling edge,
// plus literal expectations for the documented scenarios.
module tb_boot_rom_if;

  localparam int          INIT_CYCLES = 2;
  localparam logic [31:0] BASE        = 32'h1A000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic        rom_cen_o;
  logic [7:0]  rom_addr_o;
  logic [31:0] rom_q_i = 32'h0;
  logic [7:0]  err_count_o;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rom_mem [256];

  boot_rom_if #(
    .ROM_ADDR_WIDTH(8),
    .BASE_ADDR     (BASE),
    .INIT_CYCLES   (INIT_CYCLES)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .rom_cen_o    (rom_cen_o),
    .rom_addr_o   (rom_addr_o),
    .rom_q_i      (rom_q_i),
    .err_count_o  (err_count_o)
  );

  always #5 clk = ~clk;

  // ROM macro stand-in: one-cycle read latency, only when enabled.
  always @(posedge clk) begin
    if (!rom_cen_o) rom_q_i <= rom_mem[rom_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: cycles since reset release, one pending response, error tally.
  int          m_cycles = 0;
  int          m_errs   = 0;
  logic        p_valid  = 1'b0;
  logic        p_err    = 1'b0;
  logic [31:0] p_data   = 32'h0;
  logic        e_gnt, e_hit, e_cen;
  logic [7:0]  e_idx;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {31'h0, data_gnt_o}, 32'h0);
      chk("rst_cen", {31'h0, rom_cen_o}, 32'h1);
      chk("rst_addr", {24'h0, rom_addr_o}, 32'h0);
      chk("rst_rvalid", {31'h0, data_rvalid_o}, 32'h0);
      chk("rst_err", {31'h0, data_err_o}, 32'h0);
      chk("rst_rdata", data_rdata_o, 32'h0);
      chk("rst_cnt", {24'h0, err_count_o}, 32'h0);
      m_cycles = 0;
      m_errs   = 0;
      p_valid  = 1'b0;
      p_err    = 1'b0;
      p_data   = 32'h0;
    end else begin
      e_gnt = (m_cycles >= INIT_CYCLES) && data_req_i;
      e_hit = (data_addr_i >= BASE) && (data_addr_i < BASE + 32'd1024);
      e_cen = !(e_gnt && !data_we_i && e_hit);
      e_idx = 8'((data_addr_i >> 2) % 32'd256);
      chk("m_gnt", {31'h0, data_gnt_o}, {31'h0, e_gnt});
      chk("m_cen", {31'h0, rom_cen_o}, {31'h0, e_cen});
      chk("m_addr", {24'h0, rom_addr_o}, {24'h0, e_idx});
      chk("m_rvalid", {31'h0, data_rvalid_o}, {31'h0, p_valid});
      chk("m_err", {31'h0, data_err_o}, {31'h0, p_err});
      chk("m_rdata", data_rdata_o, p_data);
      chk("m_cnt", {24'h0, err_count_o}, 32'(m_errs));
      m_cycles++;
      p_valid = e_gnt;
      p_err   = e_gnt && (data_we_i || !e_hit);
      p_data  = (e_gnt && !p_err) ? rom_mem[e_idx] : 32'h0;
      if (p_err && m_errs < 255) m_errs++;
    end
  end

  task automatic set_in(input logic req, input logic we, input logic [31:0] addr);
    data_req_i   = req;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = we ? 4'hF : 4'h0;
    data_wdata_i = we ? 32'h12345678 : 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 32'hA5000000 | 32'(i);
    rom_mem[32] = 32'h1C008537;
    rom_mem[33] = 32'h08050513;
    rom_mem[34] = 32'h00050067;

    rst_n = 1'b0;
    set_in(1'b1, 1'b0, 32'h1A000080);
    repeat (3) next_cycle();
    chk("lit_rst_gnt", {31'h0, data_gnt_o}, 32'h0);
    chk("lit_rst_cen", {31'h0, rom_cen_o}, 32'h1);

    // Release with the read request already pending.
    rst_n = 1'b1;
    #2 chk("lit_init_c1_gnt", {31'h0, data_gnt_o}, 32'h0);
    chk("lit_init_c1_cen", {31'h0, rom_cen_o}, 32'h1);
    next_cycle();
    #2 chk("lit_init_c2_gnt", {31'h0, data_gnt_o}, 32'h0);
    next_cycle();
    #2 chk("lit_c3_gnt", {31'h0, data_gnt_o}, 32'h1);
    chk("lit_c3_cen", {31'h0, rom_cen_o}, 32'h0);
    chk("lit_c3_addr", {24'h0, rom_addr_o}, 32'd32);
    next_cycle();
    set_in(1'b1, 1'b0, 32'h1A000084);
    #2 chk("lit_rd32", data_rdata_o, 32'h1C008537);
    chk("lit_rd32_err", {31'h0, data_err_o}, 32'h0);
    chk("lit_c4_addr", {24'h0, rom_addr_o}, 32'd33);
    next_cycle();
    set_in(1'b1, 1'b0, 32'h1A000088);
    #2 chk("lit_rd33", data_rdata_o, 32'h08050513);
    chk("lit_c5_addr", {24'h0, rom_addr_o}, 32'd34);
    next_cycle();
    set_in(1'b1, 1'b1, 32'h1A000080);
    #2 chk("lit_rd34", data_rdata_o, 32'h00050067);
    chk("lit_wr_cen", {31'h0, rom_cen_o}, 32'h1);
    chk("lit_wr_gnt", {31'h0, data_gnt_o}, 32'h1);
    next_cycle();
    set_in(1'b1, 1'b0, 32'h1A000080);
    #2 chk("lit_wr_rvalid", {31'h0, data_rvalid_o}, 32'h1);
    chk("lit_wr_err", {31'h0, data_err_o}, 32'h1);
    chk("lit_wr_rdata", data_rdata_o, 32'h0);
    chk("lit_wr_cnt", {24'h0, err_count_o}, 32'd1);
    next_cycle();
    set_in(1'b1, 1'b0, 32'h1A000400);
    #2 chk("lit_rd_after_wr", data_rdata_o, 32'h1C008537);
    chk("lit_miss_cen", {31'h0, rom_cen_o}, 32'h1);
    next_cycle();
    set_in(1'b1, 1'b0, 32'h00000000);
    #2 chk("lit_miss1_err", {31'h0, data_err_o}, 32'h1);
    chk("lit_miss1_cnt", {24'h0, err_count_o}, 32'd2);
    chk("lit_miss0_cen", {31'h0, rom_cen_o}, 32'h1);
    next_cycle();
    set_in(1'b0, 1'b0, 32'h1A000000);
    #2 chk("lit_miss0_err", {31'h0, data_err_o}, 32'h1);
    chk("lit_miss0_rdata", data_rdata_o, 32'h0);
    chk("lit_miss0_cnt", {24'h0, err_count_o}, 32'd3);
    next_cycle();
    #2 chk("lit_idle_rvalid", {31'h0, data_rvalid_o}, 32'h0);

    // Back-to-back write errors until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      set_in(1'b1, 1'b1, BASE + 32'(i) * 32'd4);
      next_cycle();
    end
    set_in(1'b0, 1'b0, BASE);
    #2 chk("lit_sat_cnt", {24'h0, err_count_o}, 32'h000000FF);
    next_cycle();
    next_cycle();
    #2 chk("lit_sat_hold", {24'h0, err_count_o}, 32'h000000FF);

    // Read granted, then reset before its response cycle.
    next_cycle();
    set_in(1'b1, 1'b0, 32'h1A000084);
    #2 chk("lit_pre_rst_gnt", {31'h0, data_gnt_o}, 32'h1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk("lit_async_cnt", {24'h0, err_count_o}, 32'h0);
    next_cycle();
    chk("lit_disc_rvalid", {31'h0, data_rvalid_o}, 32'h0);
    chk("lit_disc_rdata", data_rdata_o, 32'h0);
    next_cycle();
    rst_n = 1'b1;
    #2 chk("lit_reinit_c1", {31'h0, data_gnt_o}, 32'h0);
    next_cycle();
    #2 chk("lit_reinit_c2", {31'h0, data_gnt_o}, 32'h0);
    next_cycle();
    #2 chk("lit_reinit_c3", {31'h0, data_gnt_o}, 32'h1);
    next_cycle();
    set_in(1'b0, 1'b0, BASE);
    #2 chk("lit_reinit_rd", data_rdata_o, 32'h08050513);
    chk("lit_reinit_cnt", {24'h0, err_count_o}, 32'h0);
    next_cycle();
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
